// File: rtl/plane_life_ctrl.sv
// plane_life_ctrl: game-flow controller for the player plane.
// Sequences IDLE -> PLAY -> BOOM -> RESPAWN/OVER, gates one-hot key
// direction into the plane, drives the explosion request, tracks lives and
// produces invincibility / blink flags for the renderer and collision logic.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   frame_tick        one-clk pulse per video frame
//   start, hit        start/restart request, plane collision (levels)
//   key_dir[3:0]      raw key direction (one-hot codes)
//   direction[3:0]    filtered direction to the plane
//   boom              explosion request to the plane
//   invincible        hits ignored while high
//   visible           sprite enable (blinks during respawn)
//   game_over         high in OVER
//   lives[1:0]        remaining lives
//   state[2:0]        IDLE=0 PLAY=1 BOOM=2 RESPAWN=3 OVER=4
module plane_life_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned BOOM_FRAMES  = 15,
  parameter int unsigned INV_FRAMES   = 120,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       hit,
  input  logic [3:0] key_dir,
  output logic [3:0] direction,
  output logic       boom,
  output logic       invincible,
  output logic       visible,
  output logic       game_over,
  output logic [1:0] lives,
  output logic [2:0] state
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LIFE_W = 2;
  localparam int unsigned DIR_W  = 4;

  localparam logic [CNT_W-1:0]  BOOM_LAST  = CNT_W'(BOOM_FRAMES - 1);
  localparam logic [CNT_W-1:0]  INV_LAST   = CNT_W'(INV_FRAMES - 1);
  localparam logic [CNT_W-1:0]  BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_BOOM    = 3'd2,
    S_RESPAWN = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic               boom_q, boom_d;
  logic               inv_q, inv_d;
  logic               vis_q, vis_d;
  logic               over_q, over_d;

  logic               onehot_c;
  logic [DIR_W-1:0]   dir_filt_c;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    onehot_c   = (key_dir != '0) && ((key_dir & (key_dir - DIR_W'(1))) == '0);
    dir_filt_c = onehot_c ? key_dir : '0;
  end

  // Next-state and next-output logic. Outputs are derived from the next
  // state so each registered flag tracks the state it belongs to.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    fcnt_d  = fcnt_q;
    bcnt_d  = '0;
    vis_d   = 1'b1;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_PLAY;
          lives_d = LIVES_INIT;
        end
      end
      S_PLAY: begin
        if (hit) begin
          state_d = S_BOOM;
          lives_d = (lives_q == '0) ? '0 : lives_q - LIFE_W'(1);
        end
      end
      S_BOOM: begin
        if (frame_tick && (fcnt_q == BOOM_LAST)) begin
          state_d = (lives_q == '0) ? S_OVER : S_RESPAWN;
        end
      end
      S_RESPAWN: begin
        if (frame_tick && (fcnt_q == INV_LAST)) begin
          state_d = S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Cleared on every state entry, so a tick on the entry edge is not counted.
    if (state_d != state_q) begin
      fcnt_d = '0;
    end else if (frame_tick && ((state_q == S_BOOM) || (state_q == S_RESPAWN))) begin
      fcnt_d = fcnt_q + CNT_W'(1);
    end

    // Blink only while staying in RESPAWN; the exit edge forces visible high.
    if ((state_q == S_RESPAWN) && (state_d == S_RESPAWN)) begin
      bcnt_d = bcnt_q;
      vis_d  = vis_q;
      if (frame_tick) begin
        if (bcnt_q == BLINK_LAST) begin
          bcnt_d = '0;
          vis_d  = ~vis_q;
        end else begin
          bcnt_d = bcnt_q + CNT_W'(1);
        end
      end
    end

    dir_d  = ((state_d == S_PLAY) || (state_d == S_RESPAWN)) ? dir_filt_c : '0;
    boom_d = (state_d == S_BOOM);
    inv_d  = (state_d == S_RESPAWN);
    over_d = (state_d == S_OVER);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lives_q <= LIVES_INIT;
      fcnt_q  <= '0;
      bcnt_q  <= '0;
      dir_q   <= '0;
      boom_q  <= 1'b0;
      inv_q   <= 1'b0;
      vis_q   <= 1'b1;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
      dir_q   <= dir_d;
      boom_q  <= boom_d;
      inv_q   <= inv_d;
      vis_q   <= vis_d;
      over_q  <= over_d;
    end
  end

  assign direction  = dir_q;
  assign boom       = boom_q;
  assign invincible = inv_q;
  assign visible    = vis_q;
  assign game_over  = over_q;
  assign lives      = lives_q;
  assign state      = state_q;

endmodule

// File: tb/tb_plane_life_ctrl.sv
// Directed bench for plane_life_ctrl with default parameters
// (LIVES=3, BOOM_FRAMES=15, INV_FRAMES=120, BLINK_FRAMES=8).
module tb_plane_life_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic       hit;
  logic [3:0] key_dir;
  logic [3:0] direction;
  logic       boom;
  logic       invincible;
  logic       visible;
  logic       game_over;
  logic [1:0] lives;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  plane_life_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .hit        (hit),
    .key_dir    (key_dir),
    .direction  (direction),
    .boom       (boom),
    .invincible (invincible),
    .visible    (visible),
    .game_over  (game_over),
    .lives      (lives),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n single-cycle frame_tick pulses, each followed by an idle cycle.
  task automatic ftick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(1);
    end
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; hit = 1'b0; key_dir = 4'b0000;
    #2;
    // Reset values
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_lives", 8'(lives), 8'd3);
    chk("rst_dir",   8'(direction), 8'd0);
    chk("rst_boom",  8'(boom), 8'd0);
    chk("rst_inv",   8'(invincible), 8'd0);
    chk("rst_over",  8'(game_over), 8'd0);
    chk("rst_vis",   8'(visible), 8'd1);
    step(2);
    rst = 1'b0;
    step(2);
    chk("idle_hold", 8'(state), 8'd0);

    // Start pulse
    start = 1'b1; step(1); start = 1'b0;
    chk("start_state", 8'(state), 8'd1);
    chk("start_lives", 8'(lives), 8'd3);
    chk("start_over",  8'(game_over), 8'd0);
    chk("start_vis",   8'(visible), 8'd1);

    // Direction filtering
    key_dir = 4'b0100; step(1);
    chk("dir_left", 8'(direction), 8'h4);
    key_dir = 4'b0110; step(1);
    chk("dir_multi", 8'(direction), 8'h0);
    key_dir = 4'b1000; step(1);
    chk("dir_right", 8'(direction), 8'h8);
    start = 1'b1; step(1); start = 1'b0;
    chk("start_in_play", 8'(state), 8'd1);
    chk("start_in_play_lives", 8'(lives), 8'd3);

    // Hit with a coincident frame tick: hit taken, tick not counted
    hit = 1'b1; frame_tick = 1'b1; step(1); hit = 1'b0; frame_tick = 1'b0;
    chk("hit1_state", 8'(state), 8'd2);
    chk("hit1_boom",  8'(boom), 8'd1);
    chk("hit1_lives", 8'(lives), 8'd2);
    chk("hit1_dir",   8'(direction), 8'd0);
    step(1);
    ftick(14);
    chk("boom14_state", 8'(state), 8'd2);
    chk("boom14_boom",  8'(boom), 8'd1);
    ftick(1);
    chk("boom15_state", 8'(state), 8'd3);
    chk("boom15_boom",  8'(boom), 8'd0);
    chk("boom15_inv",   8'(invincible), 8'd1);
    chk("boom15_vis",   8'(visible), 8'd1);

    // Blinking and hit immunity in RESPAWN
    ftick(7);
    chk("blink7_vis", 8'(visible), 8'd1);
    ftick(1);
    chk("blink8_vis", 8'(visible), 8'd0);
    hit = 1'b1; step(1); hit = 1'b0;
    chk("inv_hit_lives", 8'(lives), 8'd2);
    chk("inv_hit_state", 8'(state), 8'd3);
    ftick(8);
    chk("blink16_vis", 8'(visible), 8'd1);
    ftick(8);
    chk("blink24_vis", 8'(visible), 8'd0);
    ftick(95);
    chk("inv119_state", 8'(state), 8'd3);
    chk("inv119_vis",   8'(visible), 8'd1);
    ftick(1);
    chk("inv120_state", 8'(state), 8'd1);
    chk("inv120_inv",   8'(invincible), 8'd0);
    chk("inv120_vis",   8'(visible), 8'd1);

    // Second hit, then hit held across RESPAWN->PLAY
    hit = 1'b1; step(1); hit = 1'b0;
    chk("hit2_lives", 8'(lives), 8'd1);
    ftick(15);
    chk("hit2_resp", 8'(state), 8'd3);
    ftick(119);
    hit = 1'b1; frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    chk("held_exit_state", 8'(state), 8'd1);
    chk("held_exit_lives", 8'(lives), 8'd1);
    step(1); hit = 1'b0;
    chk("held_boom_state", 8'(state), 8'd2);
    chk("held_boom_lives", 8'(lives), 8'd0);
    chk("held_boom_boom",  8'(boom), 8'd1);

    // Last life gone -> OVER
    ftick(15);
    chk("over_state", 8'(state), 8'd4);
    chk("over_flag",  8'(game_over), 8'd1);
    chk("over_lives", 8'(lives), 8'd0);
    chk("over_boom",  8'(boom), 8'd0);
    key_dir = 4'b0001; step(1);
    chk("over_dir_up", 8'(direction), 8'd0);
    key_dir = 4'b0010; step(1);
    chk("over_dir_dn", 8'(direction), 8'd0);

    // Start and hit together in OVER: start taken
    start = 1'b1; hit = 1'b1; step(1); start = 1'b0; hit = 1'b0;
    chk("restart_state", 8'(state), 8'd1);
    chk("restart_lives", 8'(lives), 8'd3);
    chk("restart_over",  8'(game_over), 8'd0);

    // Asynchronous reset mid-BOOM
    hit = 1'b1; step(1); hit = 1'b0;
    chk("hit4_lives", 8'(lives), 8'd2);
    ftick(7);
    #2 rst = 1'b1;
    #1;
    chk("arst_boom",  8'(boom), 8'd0);
    chk("arst_state", 8'(state), 8'd0);
    chk("arst_lives", 8'(lives), 8'd3);
    step(1);
    rst = 1'b0;
    key_dir = 4'b0100; hit = 1'b1;
    ftick(3);
    hit = 1'b0;
    chk("post_rst_state", 8'(state), 8'd0);
    chk("post_rst_lives", 8'(lives), 8'd3);
    chk("post_rst_dir",   8'(direction), 8'd0);
    chk("post_rst_vis",   8'(visible), 8'd1);
    start = 1'b1; step(1); start = 1'b0;
    chk("post_rst_start", 8'(state), 8'd1);
    chk("post_rst_dir2",  8'(direction), 8'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plane_life_ctrl.md
# plane_life_ctrl

Game-flow controller that sequences the player-plane block across a life cycle: idle, play, explosion, invulnerable respawn and game over. It gates the one-hot key direction into the plane, drives the plane's `boom` input for a fixed number of frames after a hit, and tracks remaining lives. It also produces invincibility and blink flags for the renderer and collision logic. It sits between key decode / collision detect and the plane block, on the pixel clock domain.

## Interface

- `LIVES`, default 3: lives loaded on start; legal range 1..3.
- `BOOM_FRAMES`, default 15: frame ticks spent in explosion; legal range 1..255.
- `INV_FRAMES`, default 120: frame ticks of post-respawn invincibility; legal range 1..255.
- `BLINK_FRAMES`, default 8: frame ticks per `visible` half-period during invincibility; legal range 1..255.

Ports:

- `clk`, input, 1 bit: system/pixel clock; the only clock.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `frame_tick`, input, 1 bit: one-`clk` pulse per video frame.
- `start`, input, 1 bit: start/restart request; level, sampled each `clk`.
- `hit`, input, 1 bit: collision of the plane with an enemy or bullet; level, sampled each `clk`.
- `key_dir`, input, 4 bits: raw key direction; codes 0001 up, 0010 down, 0100 left, 1000 right.
- `direction`, output, 4 bits: registered direction to the plane.
- `boom`, output, 1 bit: explosion request to the plane.
- `invincible`, output, 1 bit: high while hits are ignored.
- `visible`, output, 1 bit: renderer enable for the plane sprite.
- `game_over`, output, 1 bit: high in OVER.
- `lives`, output, 2 bits: remaining lives.
- `state`, output, 3 bits: IDLE=0, PLAY=1, BOOM=2, RESPAWN=3, OVER=4.

## Operation

- Reset values:
  - `state`=IDLE, `lives`=LIVES.
  - `direction`=0000, `boom`=0, `invincible`=0, `game_over`=0, `visible`=1.
  - Frame counter = 0, blink counter = 0.
- One 8-bit frame counter `fcnt`:
  - Cleared on every state entry.
  - Increments on `frame_tick` in BOOM and RESPAWN only.
- IDLE:
  - `direction`=0.
  - `start`=1 -> PLAY; `lives`<=LIVES.
- PLAY:
  - `direction`<=`key_dir` if `key_dir` is exactly one-hot; otherwise 0000.
  - `hit`=1 -> BOOM; `lives`<=`lives`-1, saturating at 0; `boom`<=1.
- BOOM:
  - `boom`=1 and `direction`=0000 throughout.
  - When `frame_tick`=1 and `fcnt`==BOOM_FRAMES-1:
    - If `lives`==0 -> OVER.
    - Otherwise -> RESPAWN.
  - `boom`<=0 on the exit edge.
- RESPAWN:
  - `invincible`=1; `direction` filtered as in PLAY; `hit` ignored.
  - `visible` toggles each time the blink counter reaches BLINK_FRAMES-1 on a `frame_tick`; the blink counter then wraps to 0.
  - When `frame_tick`=1 and `fcnt`==INV_FRAMES-1 -> PLAY; `invincible`<=0, `visible`<=1, blink counter <=0.
- OVER:
  - `game_over`=1, `direction`=0000, `boom`=0.
  - `start`=1 -> PLAY; `lives`<=LIVES, `game_over`<=0.
- `start` is ignored in PLAY, BOOM and RESPAWN.
- `visible`=1 in every state except during RESPAWN blinking.

## Timing

- All outputs are registered.
- Every input takes effect on the `clk` edge where it is sampled; the output changes one cycle after the input is presented.
- `key_dir` to `direction` latency: 1 `clk`.
- `hit` in PLAY: `boom`=1, `lives` decremented and `state`=BOOM all in the same cycle, 1 `clk` after `hit` was presented.
- Frame-tick counting:
  - A `frame_tick` coincident with the state-entry edge is not counted.
  - BOOM therefore lasts exactly BOOM_FRAMES counted ticks; the same rule applies to RESPAWN with INV_FRAMES.
- Simultaneous events:
  - In PLAY, `hit` and `frame_tick` together: hit is taken.
  - In IDLE/OVER, `start` and `hit` together: start is taken, hit is ignored.
  - `hit` held high across RESPAWN->PLAY: a new BOOM begins 1 `clk` after PLAY is entered.
- `rst` mid-operation (any state): all outputs go to reset values immediately (asynchronously); the first `start` after release is honoured.
- `frame_tick` wider than one cycle counts once per high `clk` edge; the source guarantees single-cycle pulses.

## Test plan

- Reset then `start` pulse: `state` 0->1 one `clk` later; `lives`=3; `game_over`=0; `visible`=1.
- PLAY, `key_dir`=0100 then 0110: `direction`=0100 one `clk` later, then 0000.
- PLAY, `hit` one cycle: `boom`=1, `lives`=2, `state`=2.
  - After 15 `frame_tick` pulses: `boom`=0, `state`=3, `invincible`=1.
  - After 120 more ticks: `state`=1, `invincible`=0.
- RESPAWN with BLINK_FRAMES=8: `visible` toggles every 8 ticks; `hit` pulses produce no `lives` change.
- Three hits with full BOOM/RESPAWN sequences: after the third BOOM, `state`=4, `game_over`=1, `lives`=0, `direction`=0000 for any `key_dir`.
  - Then `start`: `state`=1, `lives`=3.
- `rst` asserted mid-BOOM (`fcnt`=7): `boom`=0, `state`=0, `lives`=3 immediately.
  - After release, no output changes until `start`.
